// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, button ASCII bases and
// the bit-period helper used by the transmitter (and a future receiver).
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_PRESS_BASE   = 8'h41;
  localparam logic [7:0] ASCII_RELEASE_BASE = 8'h61;

  // Bit period in clocks, rounded to nearest.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Bit-serial 8N1 transmitter: takes one byte per valid/ready handshake and
// shifts it out LSB first with a registered line output.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_core: bit period DIV must be at least 2");
    end
  endgenerate

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          last_tick;

  assign last_tick = (cnt_q == CW'(DIV - 1));
  // Accept a new byte at the end of the stop bit too, so frames run back-to-back.
  assign ready_o   = (state_q == ST_IDLE) || ((state_q == ST_STOP) && last_tick);
  assign tx_o      = tx_q;
  assign busy_o    = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (valid_i) begin
            shift_q <= data_i;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (last_tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (last_tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (last_tick) begin
            cnt_q <= '0;
            if (valid_i) begin
              shift_q <= data_i;
              tx_q    <= 1'b0;
              state_q <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_btn_tx.sv
// Button event logger: press/release flags become ASCII characters ('A'..'D',
// 'a'..'d') queued through a pending register and FIFO onto a UART TX line.
module uart_btn_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_flag_btn_down,
  input  logic [3:0] i_flag_btn_up,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_overflow
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);

  generate
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_btn_tx: FIFO_DEPTH must be a power of two, at least 2");
    end
  endgenerate

  logic [7:0]  pend_q, pend_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  flags;
  logic [7:0]  clr_mask;
  logic        pick_valid;
  logic [2:0]  pick_idx;
  logic [7:0]  push_code;
  logic        push;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fifo_full, fifo_empty;
  logic        pop;
  logic        core_ready, core_busy;

  assign flags = {i_flag_btn_up, i_flag_btn_down};

  // Lowest set pending bit wins: presses before releases, lower button first.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) begin
        pick_valid = 1'b1;
        pick_idx   = 3'(i);
      end
    end
  end

  assign push      = pick_valid && !fifo_full;
  assign clr_mask  = push ? (8'b1 << pick_idx) : 8'b0;
  assign push_code = pick_idx[2] ? (ASCII_RELEASE_BASE + {6'b0, pick_idx[1:0]})
                                 : (ASCII_PRESS_BASE + {6'b0, pick_idx[1:0]});

  // A flag landing on a bit that is being drained this cycle simply re-arms it.
  assign pend_d = (pend_q & ~clr_mask) | flags;
  assign ovf_d  = |(flags & pend_q & ~clr_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = core_ready && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= push_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  uart_tx_core #(
    .DIV (DIV)
  ) u_tx_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_i  (mem[rd_ptr_q[AW-1:0]]),
    .valid_i (!fifo_empty),
    .ready_o (core_ready),
    .tx_o    (o_tx),
    .busy_o  (core_busy)
  );

  assign o_busy     = core_busy || !fifo_empty || (pend_q != 8'b0);
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_btn_tx.sv
// Bench for uart_btn_tx at DIV=10: a line monitor decodes frames, expected
// characters come from the event-to-ASCII rules and lowest-index-first ordering.
module tb_uart_btn_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] down = 4'b0;
  logic [3:0] up = 4'b0;
  logic       o_tx, o_busy, o_overflow;

  int checks = 0;
  int errors = 0;

  uart_btn_tx #(
    .CLK_HZ     (1000000),
    .BAUD       (100000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_flag_btn_down (down),
    .i_flag_btn_up   (up),
    .o_tx            (o_tx),
    .o_busy          (o_busy),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;

  // Line monitor state.
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         ovf_cnt = 0;
  int         bad_frames = 0;
  bit         mon_active = 0;
  int         mon_pos = 0;
  bit         mon_ok = 1;
  logic       slot_val = 1'b1;
  logic [7:0] mon_byte = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (o_overflow === 1'b1) ovf_cnt++;
      if (!rst_n) begin
        mon_active = 0;
        continue;
      end
      if (!mon_active && o_tx === 1'b0) begin
        mon_active = 1;
        mon_pos    = 0;
        mon_ok     = 1;
      end
      if (mon_active) begin
        int slot;
        slot = mon_pos / 10;
        if (mon_pos % 10 == 0) slot_val = o_tx;
        else if (o_tx !== slot_val) mon_ok = 0;
        if (slot == 0 && o_tx !== 1'b0) mon_ok = 0;
        if (slot == 9 && o_tx !== 1'b1) mon_ok = 0;
        if (slot >= 1 && slot <= 8) mon_byte[slot-1] = o_tx;
        mon_pos++;
        if (mon_pos == 100) begin
          mon_active = 0;
          rx_q.push_back(mon_byte);
          rx_start.push_back(cyc - 99);
          if (!mon_ok) bad_frames++;
        end
      end
    end
  end

  function automatic logic [7:0] code_of(input int i);
    int v;
    v = (i < 4) ? (65 + i) : (97 + i - 4);
    return 8'(v);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic [3:0] d, input logic [3:0] u);
    @(negedge clk);
    down = d;
    up   = u;
    @(posedge clk);
    #1;
    down = 4'b0;
    up   = 4'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      #1;
      if (!o_busy && !mon_active) break;
    end
    chk({tag, "_idle"}, int'(o_busy), 0);
  endtask

  task automatic check_rx(input string tag, input bit b2b);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_char%0d", tag, i), int'(rx_q[i]), int'(exp_q[i]));
      if (b2b && i > 0)
        chk($sformatf("%s_gap%0d", tag, i), rx_start[i] - rx_start[i-1], 100);
    end
    chk({tag, "_framing"}, bad_frames, 0);
    rx_q.delete();
    rx_start.delete();
    exp_q.delete();
    bad_frames = 0;
  endtask

  initial begin
    int lows;
    logic [7:0] mask;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(o_tx), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_ovf", int'(o_overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single press: exact latency and busy drop after the stop bit
    ovf_cnt = 0;
    pulse(4'b0001, 4'b0000);
    @(negedge clk);
    chk("t1_busy_N", int'(o_busy), 1);
    chk("t1_tx_N", int'(o_tx), 1);
    @(negedge clk);
    chk("t1_tx_N1", int'(o_tx), 1);
    @(negedge clk);
    chk("t1_tx_N2", int'(o_tx), 0);
    repeat (99) @(negedge clk);
    chk("t1_busy_stop", int'(o_busy), 1);
    chk("t1_tx_stop", int'(o_tx), 1);
    @(negedge clk);
    chk("t1_busy_end", int'(o_busy), 0);
    wait_idle("t1");
    exp_q.push_back(8'h41);
    check_rx("t1", 0);
    chk("t1_ovf", ovf_cnt, 0);

    // Simultaneous events: B, D, a back-to-back
    ovf_cnt = 0;
    pulse(4'b1010, 4'b0001);
    wait_idle("t2");
    exp_q.push_back(8'h42); exp_q.push_back(8'h44); exp_q.push_back(8'h61);
    check_rx("t2", 1);
    chk("t2_ovf", ovf_cnt, 0);

    // FIFO full: events wait in pending without loss
    ovf_cnt = 0;
    pulse(4'b0001, 4'b0000);
    repeat (5) @(posedge clk);
    pulse(4'b1110, 4'b0001);
    repeat (3) @(posedge clk);
    pulse(4'b0000, 4'b0110);
    wait_idle("t3");
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    exp_q.push_back(8'h44); exp_q.push_back(8'h61); exp_q.push_back(8'h62);
    exp_q.push_back(8'h63);
    check_rx("t3", 1);
    chk("t3_ovf", ovf_cnt, 0);

    // Overflow: two presses of button 0 merge while the FIFO is full
    ovf_cnt = 0;
    pulse(4'b0000, 4'b1000);
    repeat (5) @(posedge clk);
    pulse(4'b1110, 4'b0001);
    repeat (6) @(posedge clk);
    pulse(4'b0001, 4'b0000);
    repeat (2) @(posedge clk);
    pulse(4'b0001, 4'b0000);
    wait_idle("t4");
    exp_q.push_back(8'h64); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    exp_q.push_back(8'h44); exp_q.push_back(8'h61); exp_q.push_back(8'h41);
    check_rx("t4", 1);
    chk("t4_ovf", ovf_cnt, 1);

    // Reset mid-frame during data bit 3, then a clean 'C'
    pulse(4'b0001, 4'b0000);
    repeat (46) @(posedge clk);
    #2;
    chk("t5_tx_bit3", int'(o_tx), 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_tx", int'(o_tx), 1);
    chk("t5_rst_busy", int'(o_busy), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rx_q.delete();
    rx_start.delete();
    repeat (2) @(negedge clk);
    ovf_cnt = 0;
    pulse(4'b0100, 4'b0000);
    wait_idle("t5");
    exp_q.push_back(8'h43);
    check_rx("t5", 0);
    chk("t5_ovf", ovf_cnt, 0);

    // Release of button 3, then a quiet line
    pulse(4'b0000, 4'b1000);
    wait_idle("t6");
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_tx !== 1'b1) lows++;
    end
    chk("t6_quiet", lows, 0);
    exp_q.push_back(8'h64);
    check_rx("t6", 0);

    // Random batches from idle: characters emerge in ascending bit order
    for (int b = 0; b < 8; b++) begin
      ovf_cnt = 0;
      mask = 8'($urandom_range(1, 255));
      pulse(mask[3:0], mask[7:4]);
      for (int i = 0; i < 8; i++)
        if (mask[i]) exp_q.push_back(code_of(i));
      wait_idle($sformatf("rnd%0d", b));
      check_rx($sformatf("rnd%0d", b), 1);
      chk($sformatf("rnd%0d_ovf", b), ovf_cnt, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
